// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared pipeline definitions: hazard FSM state encodings and the default
// memory-wait timeout used by the hazard controller.
// ---------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

    // Hazard controller FSM states; encodings are visible on the state port.
    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_IMEM_WAIT  = 2'd2,
        ST_DMEM_WAIT  = 2'd3
    } hz_state_e;

    // Default number of memory-wait cycles before declaring a timeout.
    localparam int unsigned MAX_WAIT_DEFAULT = 15;

    // Width of the memory-wait cycle counter.
    localparam int unsigned WAIT_CNT_W = 8;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Load-use comparator: flags when the load in EX writes a register that the
// instruction in ID reads. Register 0 is hard-wired to zero and never
// creates a dependency. Shared with the forwarding logic.
//
// Ports:
//   ex_mem_read_i  EX instruction is a load
//   ex_rt_i        load destination register
//   id_rs_i        ID rs field
//   id_rt_i        ID rt field
//   id_uses_rt_i   ID instruction actually reads rt
//   load_use_o     dependency detected
// ---------------------------------------------------------------------------
module hazard_detect (
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rt_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    output logic       load_use_o
);

    logic rs_match;
    logic rt_match;

    assign rs_match   = (ex_rt_i == id_rs_i);
    assign rt_match   = id_uses_rt_i && (ex_rt_i == id_rt_i);
    assign load_use_o = ex_mem_read_i && (ex_rt_i != 5'd0) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Pipeline hazard controller. Decides each cycle whether the PC advances,
// whether IF/ID holds or is flushed, whether ID/EX gets a bubble and whether
// the back end freezes. Covers load-use stalls, taken-branch flushes and
// instruction/data memory waits with a timeout. Outputs are Mealy: they
// react in the same cycle the condition is seen.
//
// Parameters:
//   CNT_W     width of the saturating stall counter
//   MAX_WAIT  memory-wait cycles before timeout (1..255)
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   id_rs, id_rt, id_uses_rt      ID instruction source operands
//   ex_mem_read, ex_rt            load in EX and its destination
//   branch_taken                  branch resolved taken
//   imem_ready                    instruction fetch data valid
//   dmem_req, dmem_ready          data memory access / completion
//   pc_write_en                   PC loads next value
//   if_id_hold, if_id_flush       IF/ID hold / insert bubble
//   id_ex_bubble                  zero ID/EX control fields
//   back_hold                     freeze EX/MEM and MEM/WB
//   state                         FSM state encoding
//   stall_count                   cycles with pc_write_en=0 (saturating)
//   timeout_err                   sticky memory-timeout flag
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write_en,
    output logic             if_id_hold,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             back_hold,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic             timeout_err
);

    // Counter value during the final permitted wait cycle.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MAX_WAIT - 1);

    hz_state_e              state_q, state_d;
    logic [WAIT_CNT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]       stall_q;
    logic                   timeout_q;
    logic                   timeout_set;

    logic pc_we_c, hold_c, flush_c, bubble_c, back_hold_c;
    logic load_use;

    hazard_detect u_hazard_detect (
        .ex_mem_read_i (ex_mem_read),
        .ex_rt_i       (ex_rt),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_uses_rt_i  (id_uses_rt),
        .load_use_o    (load_use)
    );

    // Next state and Mealy controls. Branches are deliberately not examined
    // outside RUN: the branch source holds the request until we are back.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        timeout_set = 1'b0;
        pc_we_c     = 1'b1;
        hold_c      = 1'b0;
        flush_c     = 1'b0;
        bubble_c    = 1'b0;
        back_hold_c = 1'b0;

        case (state_q)
            ST_RUN: begin
                // Clearing here means the counter is zero on entry to a wait.
                wait_d = '0;
                if (dmem_req && !dmem_ready) begin
                    state_d     = ST_DMEM_WAIT;
                    pc_we_c     = 1'b0;
                    hold_c      = 1'b1;
                    back_hold_c = 1'b1;
                end else if (branch_taken) begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                end else if (load_use) begin
                    state_d  = ST_LOAD_STALL;
                    pc_we_c  = 1'b0;
                    hold_c   = 1'b1;
                    bubble_c = 1'b1;
                end else if (!imem_ready) begin
                    state_d = ST_IMEM_WAIT;
                    pc_we_c = 1'b0;
                    flush_c = 1'b1;
                end
            end

            ST_LOAD_STALL: begin
                state_d = ST_RUN;
            end

            ST_IMEM_WAIT: begin
                if (imem_ready) begin
                    state_d = ST_RUN;
                end else begin
                    pc_we_c = 1'b0;
                    flush_c = 1'b1;
                    if (wait_q == WAIT_LAST) begin
                        state_d     = ST_RUN;
                        timeout_set = 1'b1;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
            end

            ST_DMEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = ST_RUN;
                end else begin
                    pc_we_c     = 1'b0;
                    hold_c      = 1'b1;
                    back_hold_c = 1'b1;
                    if (wait_q == WAIT_LAST) begin
                        state_d     = ST_RUN;
                        timeout_set = 1'b1;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            wait_q    <= '0;
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (!pc_we_c && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Reset forces the quiescent values onto every output in the reset
    // cycle itself, independent of the (possibly unknown) register contents.
    assign pc_write_en  = reset | pc_we_c;
    assign if_id_hold   = ~reset & hold_c;
    assign if_id_flush  = ~reset & flush_c;
    assign id_ex_bubble = ~reset & bubble_c;
    assign back_hold    = ~reset & back_hold_c;
    assign state        = reset ? ST_RUN : state_q;
    assign stall_count  = reset ? '0 : stall_q;
    assign timeout_err  = ~reset & timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned MAX_WAIT = 4;

    logic             clk;
    logic             reset;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             branch_taken;
    logic             imem_ready;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_write_en;
    logic             if_id_hold;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             back_hold;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_count;
    logic             timeout_err;

    int checks   = 0;
    int failures = 0;

    // {pc_write_en, if_id_hold, if_id_flush, id_ex_bubble, back_hold, state}
    logic [6:0] ctl;
    assign ctl = {pc_write_en, if_id_hold, if_id_flush, id_ex_bubble, back_hold, state};

    localparam logic [6:0] C_RUN    = 7'b10000_00;
    localparam logic [6:0] C_LU     = 7'b01010_00;
    localparam logic [6:0] C_LSTALL = 7'b10000_01;
    localparam logic [6:0] C_BR     = 7'b10110_00;
    localparam logic [6:0] C_D_RUN  = 7'b01001_00;
    localparam logic [6:0] C_D_WAIT = 7'b01001_11;
    localparam logic [6:0] C_D_DONE = 7'b10000_11;
    localparam logic [6:0] C_I_RUN  = 7'b00100_00;
    localparam logic [6:0] C_I_WAIT = 7'b00100_10;
    localparam logic [6:0] C_I_DONE = 7'b10000_10;

    pipeline_hazard_ctrl #(
        .CNT_W    (CNT_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .branch_taken (branch_taken),
        .imem_ready   (imem_ready),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .pc_write_en  (pc_write_en),
        .if_id_hold   (if_id_hold),
        .if_id_flush  (if_id_flush),
        .id_ex_bubble (id_ex_bubble),
        .back_hold    (back_hold),
        .state        (state),
        .stall_count  (stall_count),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        id_rs        = 5'd1;
        id_rt        = 5'd2;
        id_uses_rt   = 1'b0;
        ex_mem_read  = 1'b0;
        ex_rt        = 5'd0;
        branch_taken = 1'b0;
        imem_ready   = 1'b1;
        dmem_req     = 1'b0;
        dmem_ready   = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== C_RUN) begin
            failures++;
            $display("FAIL reset_ctl: got %b expected %b", ctl, C_RUN);
        end
        checks++;
        if (stall_count !== 4'd0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_cnt: got stall=%0d to=%b expected 0/0", stall_count, timeout_err);
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== C_RUN || stall_count !== 4'd0) begin
            failures++;
            $display("FAIL reset_after: got %b stall=%0d expected %b stall=0", ctl, stall_count, C_RUN);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        logic [6:0] exp_seq [3] = '{C_LU, C_LSTALL, C_RUN};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ex_mem_read = (i == 0);
            ex_rt       = 5'd5;
            id_rs       = 5'd5;
            @(negedge clk);
            checks++;
            if (ctl !== exp_seq[i]) begin
                failures++;
                $display("FAIL load_use_c%0d: got %b expected %b", i, ctl, exp_seq[i]);
            end
            next_cycle();
        end
        checks++;
        if (stall_count !== 4'd1) begin
            failures++;
            $display("FAIL load_use_count: got %0d expected 1", stall_count);
        end
    endtask

    task automatic test_reg_zero();
        do_reset();
        ex_mem_read = 1'b1;
        ex_rt       = 5'd0;
        id_rs       = 5'd0;
        id_rt       = 5'd0;
        id_uses_rt  = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== C_RUN) begin
            failures++;
            $display("FAIL reg_zero: got %b expected %b", ctl, C_RUN);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (ctl !== C_RUN || stall_count !== 4'd0) begin
            failures++;
            $display("FAIL reg_zero_after: got %b stall=%0d expected %b stall=0", ctl, stall_count, C_RUN);
        end
        next_cycle();
    endtask

    task automatic test_rt_compare();
        do_reset();
        // rt matches but is not read: no stall
        ex_mem_read = 1'b1;
        ex_rt       = 5'd7;
        id_rs       = 5'd3;
        id_rt       = 5'd7;
        id_uses_rt  = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== C_RUN) begin
            failures++;
            $display("FAIL rt_unused: got %b expected %b", ctl, C_RUN);
        end
        next_cycle();
        // rt matches and is read: stall
        id_uses_rt = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== C_LU) begin
            failures++;
            $display("FAIL rt_used: got %b expected %b", ctl, C_LU);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_branch_priority();
        do_reset();
        branch_taken = 1'b1;
        ex_mem_read  = 1'b1;
        ex_rt        = 5'd9;
        id_rs        = 5'd9;
        @(negedge clk);
        checks++;
        if (ctl !== C_BR) begin
            failures++;
            $display("FAIL branch_flush: got %b expected %b", ctl, C_BR);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (ctl !== C_RUN || stall_count !== 4'd0) begin
            failures++;
            $display("FAIL branch_after: got %b stall=%0d expected %b stall=0", ctl, stall_count, C_RUN);
        end
        next_cycle();
    endtask

    task automatic test_dmem_wait();
        logic [6:0] exp_seq [5] = '{C_D_RUN, C_D_WAIT, C_D_WAIT, C_D_DONE, C_RUN};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            dmem_req     = (i < 4);
            dmem_ready   = (i == 3);
            branch_taken = (i < 4);
            @(negedge clk);
            checks++;
            if (ctl !== exp_seq[i]) begin
                failures++;
                $display("FAIL dmem_c%0d: got %b expected %b", i, ctl, exp_seq[i]);
            end
            next_cycle();
        end
        idle_inputs();
        checks++;
        if (stall_count !== 4'd3 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL dmem_count: got stall=%0d to=%b expected 3/0", stall_count, timeout_err);
        end
    endtask

    task automatic test_imem_early();
        do_reset();
        imem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== C_I_RUN) begin
            failures++;
            $display("FAIL imem_early_c0: got %b expected %b", ctl, C_I_RUN);
        end
        next_cycle();
        imem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== C_I_DONE) begin
            failures++;
            $display("FAIL imem_early_c1: got %b expected %b", ctl, C_I_DONE);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (ctl !== C_RUN || stall_count !== 4'd1 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL imem_early_end: got %b stall=%0d to=%b expected %b 1 0", ctl, stall_count, timeout_err, C_RUN);
        end
        next_cycle();
    endtask

    task automatic test_imem_timeout();
        logic [6:0] exp_seq [5] = '{C_I_RUN, C_I_WAIT, C_I_WAIT, C_I_WAIT, C_I_WAIT};
        do_reset();
        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (ctl !== exp_seq[i] || timeout_err !== 1'b0) begin
                failures++;
                $display("FAIL imem_to_c%0d: got %b to=%b expected %b to=0", i, ctl, timeout_err, exp_seq[i]);
            end
            next_cycle();
        end
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ctl !== C_RUN || timeout_err !== 1'b1 || stall_count !== 4'd5) begin
                failures++;
                $display("FAIL imem_to_after%0d: got %b to=%b stall=%0d expected %b to=1 stall=5",
                         i, ctl, timeout_err, stall_count, C_RUN);
            end
            next_cycle();
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0 || stall_count !== 4'd0) begin
            failures++;
            $display("FAIL imem_to_cleared: got to=%b stall=%0d expected 0/0", timeout_err, stall_count);
        end
        next_cycle();
    endtask

    task automatic test_reset_in_dmem();
        do_reset();
        dmem_req   = 1'b1;
        dmem_ready = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if (ctl !== C_D_WAIT) begin
            failures++;
            $display("FAIL rst_dmem_enter: got %b expected %b", ctl, C_D_WAIT);
        end
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== C_RUN || stall_count !== 4'd0) begin
            failures++;
            $display("FAIL rst_dmem_during: got %b stall=%0d expected %b stall=0", ctl, stall_count, C_RUN);
        end
        next_cycle();
        reset    = 1'b0;
        dmem_req = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== C_RUN || stall_count !== 4'd0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_dmem_after: got %b stall=%0d to=%b expected %b 0 0", ctl, stall_count, timeout_err, C_RUN);
        end
        next_cycle();
    endtask

    task automatic test_saturation();
        int both = 0;
        do_reset();
        imem_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if_id_hold && if_id_flush) both++;
            next_cycle();
        end
        imem_ready = 1'b1;
        checks++;
        if (both != 0) begin
            failures++;
            $display("FAIL hold_flush_exclusive: got %0d overlapping cycles expected 0", both);
        end
        @(negedge clk);
        checks++;
        if (stall_count !== 4'hF) begin
            failures++;
            $display("FAIL stall_saturate: got %0d expected 15", stall_count);
        end
        next_cycle();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_load_use();
        test_reg_zero();
        test_rt_compare();
        test_branch_priority();
        test_dmem_wait();
        test_imem_early();
        test_imem_timeout();
        test_reset_in_dmem();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
